// File: rtl/bsg_downstream_in.sv
// BSG link receiver: reassembles 64-bit words from four two-byte beats,
// buffers them in a small FIFO for the core and returns credit tokens upstream.
module bsg_downstream_in #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TOKEN_RATIO = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_valid_in,
    input  logic [7:0]  io_data_in_ch0,
    input  logic [7:0]  io_data_in_ch1,
    output logic        io_token,
    output logic [63:0] core_data_out,
    output logic        core_valid_out,
    input  logic        core_yumi_in,
    output logic [1:0]  beat_idx,
    output logic        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TOKEN_RATIO + 1);

    logic [63:0]   asm_word;
    logic [63:0]   full_word;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tok_cnt;

    logic last_beat;
    logic fifo_full;
    logic deq;
    logic enq;
    logic drop;

    assign last_beat = io_valid_in && (beat_idx == 2'd3);
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign deq       = core_yumi_in && (count != '0);
    // A full FIFO can still accept the word if the head leaves on the same edge.
    assign enq       = last_beat && (!fifo_full || deq);
    assign drop      = last_beat && fifo_full && !deq;

    assign core_valid_out = (count != '0);
    assign core_data_out  = mem[rd_ptr];

    always_comb begin
        full_word        = asm_word;
        full_word[47:40] = io_data_in_ch0;
        full_word[63:56] = io_data_in_ch1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_word <= '0;
            beat_idx <= 2'd0;
        end else if (io_valid_in) begin
            case (beat_idx)
                2'd0: begin
                    asm_word[7:0]   <= io_data_in_ch0;
                    asm_word[23:16] <= io_data_in_ch1;
                end
                2'd1: begin
                    asm_word[15:8]  <= io_data_in_ch0;
                    asm_word[31:24] <= io_data_in_ch1;
                end
                2'd2: begin
                    asm_word[39:32] <= io_data_in_ch0;
                    asm_word[55:48] <= io_data_in_ch1;
                end
                default: begin
                    asm_word[47:40] <= io_data_in_ch0;
                    asm_word[63:56] <= io_data_in_ch1;
                end
            endcase
            beat_idx <= beat_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= full_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // io_token is registered so each completed batch yields exactly one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_cnt  <= '0;
            io_token <= 1'b0;
        end else begin
            io_token <= 1'b0;
            if (deq) begin
                if (tok_cnt == TW'(TOKEN_RATIO - 1)) begin
                    tok_cnt  <= '0;
                    io_token <= 1'b1;
                end else begin
                    tok_cnt <= tok_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_downstream_in.sv
// Randomized and directed bench for bsg_downstream_in, checked against a
// queue-based model of word reassembly, buffering and token pacing.
module tb_bsg_downstream_in;

    localparam int DEPTH = 4;
    localparam int RATIO = 2;

    logic        clk;
    logic        rst_n;
    logic        io_valid_in;
    logic [7:0]  io_data_in_ch0;
    logic [7:0]  io_data_in_ch1;
    logic        io_token;
    logic [63:0] core_data_out;
    logic        core_valid_out;
    logic        core_yumi_in;
    logic [1:0]  beat_idx;
    logic        overflow;

    bsg_downstream_in #(.FIFO_DEPTH(DEPTH), .TOKEN_RATIO(RATIO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .io_valid_in    (io_valid_in),
        .io_data_in_ch0 (io_data_in_ch0),
        .io_data_in_ch1 (io_data_in_ch1),
        .io_token       (io_token),
        .core_data_out  (core_data_out),
        .core_valid_out (core_valid_out),
        .core_yumi_in   (core_yumi_in),
        .beat_idx       (beat_idx),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte lane offsets of each beat inside the 64-bit word.
    int pos0 [4] = '{0, 8, 32, 40};
    int pos1 [4] = '{16, 24, 48, 56};

    logic [63:0] m_q [$];
    logic [7:0]  m_b0 [4];
    logic [7:0]  m_b1 [4];
    int          m_beat;
    bit          m_ovf;
    int          m_deqs;
    bit          m_tok;

    int checks;
    int errors;
    int tok_seen;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_beat = 0;
        m_ovf  = 1'b0;
        m_deqs = 0;
        m_tok  = 1'b0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic applyStimulus(input bit v, input logic [7:0] c0, input logic [7:0] c1, input bit y);
        logic [63:0] w;
        bit          was_full;
        bit          deq;
        io_valid_in    = v;
        io_data_in_ch0 = c0;
        io_data_in_ch1 = c1;
        core_yumi_in   = y;
        @(posedge clk);
        was_full = (m_q.size() == DEPTH);
        deq      = y && (m_q.size() != 0);
        m_tok    = 1'b0;
        if (deq) begin
            void'(m_q.pop_front());
            m_deqs++;
            m_tok = (m_deqs % RATIO) == 0;
        end
        if (v) begin
            m_b0[m_beat] = c0;
            m_b1[m_beat] = c1;
            if (m_beat == 3) begin
                w = '0;
                for (int b = 0; b < 4; b++) begin
                    w[pos0[b] +: 8] = m_b0[b];
                    w[pos1[b] +: 8] = m_b1[b];
                end
                if (was_full && !deq) m_ovf = 1'b1;
                else                  m_q.push_back(w);
            end
            m_beat = (m_beat + 1) % 4;
        end
        #1;
        if (io_token) tok_seen++;
        checkOutput("valid", 64'(core_valid_out), 64'(m_q.size() != 0));
        checkOutput("beat_idx", 64'(beat_idx), 64'(m_beat));
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
        checkOutput("io_token", 64'(io_token), 64'(m_tok));
        if (m_q.size() != 0) checkOutput("data", core_data_out, m_q[0]);
    endtask

    task automatic send_word(input logic [63:0] w, input int gap, input bit yumi_last);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, w[pos0[b] +: 8], w[pos1[b] +: 8], yumi_last && (b == 3));
            for (int g = 0; g < gap && b < 3; g++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        end
    endtask

    task automatic dequeue(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    // Reset lands mid-cycle so the outputs must clear without a clock edge.
    task automatic pulse_reset();
        io_valid_in  = 1'b0;
        core_yumi_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_token", 64'(io_token), 64'd0);
        checkOutput("rst_valid", 64'(core_valid_out), 64'd0);
        checkOutput("rst_data", core_data_out, 64'd0);
        checkOutput("rst_beat", 64'(beat_idx), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        tok_seen       = 0;
        rst_n          = 1'b0;
        io_valid_in    = 1'b0;
        io_data_in_ch0 = 8'h00;
        io_data_in_ch1 = 8'h00;
        core_yumi_in   = 1'b0;
        model_clear();
        #1;
        checkOutput("init_valid", 64'(core_valid_out), 64'd0);
        checkOutput("init_data", core_data_out, 64'd0);
        checkOutput("init_beat", 64'(beat_idx), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reassembly");
        applyStimulus(1'b1, 8'hEF, 8'hAB, 1'b0);
        applyStimulus(1'b1, 8'hCD, 8'h89, 1'b0);
        applyStimulus(1'b1, 8'h67, 8'h23, 1'b0);
        applyStimulus(1'b1, 8'h45, 8'h01, 1'b0);
        checkOutput("word_const", core_data_out, 64'h0123456789ABCDEF);
        dequeue(1);

        $display("[TB] gapped beats");
        send_word(64'h0123456789ABCDEF, 3, 1'b0);
        checkOutput("gap_const", core_data_out, 64'h0123456789ABCDEF);
        dequeue(1);

        $display("[TB] fill and overflow");
        pulse_reset();
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 0, 1'b0);
        checkOutput("full_no_ovf", 64'(overflow), 64'd0);
        send_word({$urandom, $urandom}, 0, 1'b0);
        checkOutput("ovf_set", 64'(overflow), 64'd1);
        dequeue(4);
        checkOutput("drained", 64'(core_valid_out), 64'd0);

        $display("[TB] enqueue while full with yumi");
        pulse_reset();
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 1, 1'b0);
        send_word(64'hFEEDFACE_CAFEF00D, 0, 1'b1);
        checkOutput("full_yumi_ovf", 64'(overflow), 64'd0);
        dequeue(3);
        checkOutput("last_word", core_data_out, 64'hFEEDFACE_CAFEF00D);
        dequeue(1);

        $display("[TB] token pacing");
        pulse_reset();
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 0, 1'b0);
        tok_seen = 0;
        dequeue(4);
        send_word({$urandom, $urandom}, 0, 1'b0);
        dequeue(1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("token_pulses", 64'(tok_seen), 64'd2);

        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 8'h11, 8'h22, 1'b0);
        applyStimulus(1'b1, 8'h33, 8'h44, 1'b0);
        pulse_reset();
        send_word(64'h8877665544332211, 0, 1'b0);
        checkOutput("fresh_word", core_data_out, 64'h8877665544332211);
        dequeue(1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                          ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
